// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 key sequencer.
//   - FSM state enum, scan prefix bytes, {ext, code} key type
//   - make-code to ASCII translation table
//   - default parameter values
package kbd_pkg;

  localparam int unsigned DEPTH_DEF           = 4;
  localparam int unsigned TIMEOUT_CYC_DEF     = 2_000_000;
  localparam bit          REPEAT_SUPPRESS_DEF = 1'b1;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kbd_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } kbd_key_t;

  // Fixed scan-code table; anything not listed (including keypad codes
  // without the E0 prefix) yields 8'h00, meaning "no character".
  function automatic logic [7:0] kbd_translate(kbd_key_t key);
    logic [7:0] ch;
    ch = 8'h00;
    case ({key.ext, key.code})
      9'h005:  ch = 8'h21;
      9'h006:  ch = 8'h22;
      9'h01C:  ch = 8'h41;
      9'h023:  ch = 8'h44;
      9'h02B:  ch = 8'h46;
      9'h033:  ch = 8'h48;
      9'h03A:  ch = 8'h4D;
      9'h02D:  ch = 8'h52;
      9'h01B:  ch = 8'h53;
      9'h02C:  ch = 8'h54;
      9'h05A:  ch = 8'h0D;
      9'h172:  ch = 8'h35;
      9'h16B:  ch = 8'h34;
      9'h174:  ch = 8'h36;
      9'h175:  ch = 8'h38;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// Character FIFO with registered head and sticky overflow flag.
//   push_i/data_i : write a character (dropped and flagged when full
//                   unless a pop happens in the same cycle)
//   pop_i         : remove the head (ignored when empty)
//   clr_ovf_i     : clear the overflow flag (a same-cycle drop wins)
//   head_o        : current head, 8'h00 when empty
//   empty_o/full_o/overflow_o : status
module kbd_char_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  input  logic       clr_ovf_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          ovf_q, ovf_d;
  logic          do_pop, do_push, drop;

  // Pointer, occupancy, head and overflow next-state.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    drop     = push_i && !do_push;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);

    head_d = head_q;
    if (count_d == '0) begin
      head_d = 8'h00;
    end else if (do_pop) begin
      // With one entry left the only survivor is the incoming character.
      head_d = (count_q > CW'(1)) ? mem_q[rd_ptr_d] : data_i;
    end else if (count_q == '0) begin
      head_d = data_i;
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_o     = head_q;
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign overflow_o = ovf_q;

endmodule

// File: rtl/kbd_key_sequencer.sv
// PS/2 scan-byte sequencer: tracks E0/F0 prefixes, filters typematic
// repeats, translates make codes to ASCII and buffers them for the MCU.
//   rx_byte/rx_done_tick : incoming scan byte strobe
//   rd_tick              : pop FIFO head
//   clr_ovf              : clear sticky overflow
//   ascii_code           : FIFO head (8'h00 when empty)
//   key_avail/fifo_full/overflow : FIFO status
module kbd_key_sequencer
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH           = DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYC     = TIMEOUT_CYC_DEF,
  parameter bit          REPEAT_SUPPRESS = REPEAT_SUPPRESS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_done_tick,
  input  logic       rd_tick,
  input  logic       clr_ovf,
  output logic [7:0] ascii_code,
  output logic       key_avail,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  kbd_state_e    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  kbd_key_t      held_key_q, held_key_d;
  logic          held_valid_q, held_valid_d;

  kbd_key_t      key;
  logic          do_make, do_break, suppress;
  logic          push_en;
  logic [7:0]    push_char;
  logic          fifo_empty;

  // Prefix FSM, timeout, repeat filter and translation.
  always_comb begin
    state_d      = state_q;
    tmo_d        = '0;
    held_key_d   = held_key_q;
    held_valid_d = held_valid_q;
    do_make      = 1'b0;
    do_break     = 1'b0;
    suppress     = 1'b0;
    push_en      = 1'b0;
    push_char    = 8'h00;
    key.ext      = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    key.code     = rx_byte;

    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_d = ST_EXT;
          end else if (rx_byte == SC_BRK) begin
            state_d = ST_BRK;
          end else begin
            do_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_byte != SC_EXT) begin
            do_make = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          do_break = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Abandon a prefix whose follow-up byte never arrived.
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (do_make) begin
      suppress = REPEAT_SUPPRESS && held_valid_q && (key == held_key_q);
      if (!suppress) begin
        held_key_d   = key;
        held_valid_d = 1'b1;
        push_char    = kbd_translate(key);
        push_en      = (push_char != 8'h00);
      end
    end

    if (do_break && held_valid_q && (key == held_key_q)) begin
      held_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      held_key_q   <= '0;
      held_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      held_key_q   <= held_key_d;
      held_valid_q <= held_valid_d;
    end
  end

  kbd_char_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (push_en),
    .data_i    (push_char),
    .pop_i     (rd_tick),
    .clr_ovf_i (clr_ovf),
    .head_o    (ascii_code),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .overflow_o(overflow)
  );

  assign key_avail = !fifo_empty;

endmodule
